tl_countdown_display: RTL

TL_COUNTDOWN_DISPLAY -- requirements
Module: tl_countdown_display

---
 rtl/tl_countdown_display.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/tl_countdown_display.sv
// rtl/tl_countdown_display.sv - multiplexed 4-digit countdown display for traffic light timers
// Optional build macro: LEADING_ZERO_BLANK_EN suppresses tens digits that are zero.
module tl_countdown_display #(
  parameter int SCAN_DIV     = 50000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [5:0] ns_time,
  input  logic [5:0] ew_time,
  input  logic       ns_yellow,
  input  logic       ew_yellow,
  output logic [7:0] seg,
  output logic [3:0] an
);

  localparam logic [19:0] PRESC_LAST = 20'(SCAN_DIV - 1);
  localparam logic [7:0]  FRAME_LAST = 8'(BLINK_FRAMES - 1);

  logic [19:0] presc_q, presc_d;
  logic [1:0]  digit_q, digit_d;
  logic [7:0]  frame_q, frame_d;
  logic        blink_q, blink_d;
  logic [5:0]  ns_sh_q, ns_sh_d, ew_sh_q, ew_sh_d;
  logic        nsy_sh_q, nsy_sh_d, ewy_sh_q, ewy_sh_d;
  logic [7:0]  seg_q, seg_d;
  logic [3:0]  an_q, an_d;

  logic        tc, wrap;
  logic [2:0]  ns_tens, ew_tens;
  logic [3:0]  ns_ones, ew_ones;
  logic [3:0]  digit_val;
  logic        is_tens, pair_yellow, lz_blank, blank;

  function automatic logic [2:0] tens_of(input logic [5:0] v);
    if      (v >= 6'd60) return 3'd6;
    else if (v >= 6'd50) return 3'd5;
    else if (v >= 6'd40) return 3'd4;
    else if (v >= 6'd30) return 3'd3;
    else if (v >= 6'd20) return 3'd2;
    else if (v >= 6'd10) return 3'd1;
    else                 return 3'd0;
  endfunction

  function automatic logic [3:0] ones_of(input logic [5:0] v, input logic [2:0] t);
    logic [5:0] rem;
    rem = v - ({3'b000, t} * 6'd10);
    return rem[3:0];
  endfunction

  function automatic logic [7:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    return 8'hC0;
      4'd1:    return 8'hF9;
      4'd2:    return 8'hA4;
      4'd3:    return 8'hB0;
      4'd4:    return 8'h99;
      4'd5:    return 8'h92;
      4'd6:    return 8'h82;
      4'd7:    return 8'hF8;
      4'd8:    return 8'h80;
      4'd9:    return 8'h90;
      default: return 8'hFF;
    endcase
  endfunction

  assign tc      = (presc_q == PRESC_LAST);
  assign wrap    = tc && (digit_q == 2'd3);
  assign ns_tens = tens_of(ns_sh_q);
  assign ew_tens = tens_of(ew_sh_q);
  assign ns_ones = ones_of(ns_sh_q, ns_tens);
  assign ew_ones = ones_of(ew_sh_q, ew_tens);

  // Sequencing and frame-boundary capture
  always_comb begin
    presc_d  = tc ? 20'd0 : presc_q + 20'd1;
    digit_d  = digit_q;
    frame_d  = frame_q;
    blink_d  = blink_q;
    ns_sh_d  = ns_sh_q;
    ew_sh_d  = ew_sh_q;
    nsy_sh_d = nsy_sh_q;
    ewy_sh_d = ewy_sh_q;
    if (tc) begin
      digit_d = digit_q + 2'd1;
    end
    if (wrap) begin
      ns_sh_d  = ns_time;
      ew_sh_d  = ew_time;
      nsy_sh_d = ns_yellow;
      ewy_sh_d = ew_yellow;
      if (frame_q >= FRAME_LAST) begin
        frame_d = 8'd0;
        blink_d = ~blink_q;
      end else begin
        frame_d = frame_q + 8'd1;
      end
    end
  end

  // Slot content is taken from the current digit; registered on the next edge
  always_comb begin
    digit_val   = 4'd0;
    is_tens     = 1'b0;
    pair_yellow = 1'b0;
    case (digit_q)
      2'd0: begin digit_val = ew_ones;         pair_yellow = ewy_sh_q; end
      2'd1: begin digit_val = {1'b0, ew_tens}; pair_yellow = ewy_sh_q; is_tens = 1'b1; end
      2'd2: begin digit_val = ns_ones;         pair_yellow = nsy_sh_q; end
      default: begin digit_val = {1'b0, ns_tens}; pair_yellow = nsy_sh_q; is_tens = 1'b1; end
    endcase
`ifdef LEADING_ZERO_BLANK_EN
    lz_blank = is_tens && (digit_val == 4'd0);
`else
    lz_blank = 1'b0;
`endif
    blank = !enable || (pair_yellow && blink_q) || lz_blank;
    an_d  = blank ? 4'hF  : ~(4'b0001 << digit_q);
    seg_d = blank ? 8'hFF : seg_decode(digit_val);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      presc_q  <= 20'd0;
      digit_q  <= 2'd0;
      frame_q  <= 8'd0;
      blink_q  <= 1'b0;
      ns_sh_q  <= 6'd0;
      ew_sh_q  <= 6'd0;
      nsy_sh_q <= 1'b0;
      ewy_sh_q <= 1'b0;
      an_q     <= 4'hF;
      seg_q    <= 8'hFF;
    end else begin
      presc_q  <= presc_d;
      digit_q  <= digit_d;
      frame_q  <= frame_d;
      blink_q  <= blink_d;
      ns_sh_q  <= ns_sh_d;
      ew_sh_q  <= ew_sh_d;
      nsy_sh_q <= nsy_sh_d;
      ewy_sh_q <= ewy_sh_d;
      an_q     <= an_d;
      seg_q    <= seg_d;
    end
  end

  assign seg = seg_q;
  assign an  = an_q;

endmodule
